dither_sequencer: RTL

//  Frame-synchronous sequencer for the ordered dither stage between rbzero's 6-bit

---
 rtl/dither_sequencer.sv | 119 +++++++++++
 1 files changed

// File: rtl/dither_sequencer.sv
// Frame-synchronous sequencer for the ordered dither stage: detects vsync in the clk
// domain, steps dither field/phase per frame, and commits mode changes at frame edges.
module dither_sequencer #(
  parameter int         FRAME_W    = 8,
  parameter int         FRAME_DIV  = 1,
  parameter logic [1:0] RESET_MODE = 2'b01
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync_n,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic               frame_tick,
  output logic               field,
  output logic [1:0]         phase,
  output logic [1:0]         mode,
  output logic [FRAME_W-1:0] frame_count,
  output logic               cfg_state
);

  // Config handshake: a request transfers on any clk edge where cfg_valid && cfg_ready.
  // cfg_ready is a decode of the registered FSM state, so it never depends on cfg_valid.
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);

  cfg_state_t state, state_nxt;
  logic       accept, commit;
  logic       vs_d, run;
  logic [1:0] shadow;
  logic [3:0] div_cnt;
  logic       step;
  logic [1:0] phase_next;

  assign step       = (div_cnt == DIV_LAST);
  assign phase_next = phase + 2'd1;
  assign cfg_state  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept    = 1'b1;
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_tick) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      vs_d        <= 1'b1;
      frame_tick  <= 1'b0;
      field       <= 1'b0;
      phase       <= 2'd0;
      div_cnt     <= 4'd0;
      frame_count <= '0;
      mode        <= RESET_MODE;
      shadow      <= 2'd0;
    end else begin
      // The first edge after release only primes vs_d, so a vsync already low gives no tick.
      run        <= 1'b1;
      vs_d       <= vsync_n;
      frame_tick <= run & vs_d & ~vsync_n;
      if (accept) shadow <= cfg_mode;
      if (frame_tick) begin
        frame_count <= frame_count + FRAME_W'(1);
        if (commit) begin
          mode    <= shadow;
          field   <= 1'b0;
          phase   <= 2'd0;
          div_cnt <= 4'd0;
        end else begin
          div_cnt <= step ? 4'd0 : div_cnt + 4'd1;
          if (step) begin
            case (mode)
              2'b00: begin
                field <= 1'b0;
                phase <= 2'd0;
              end
              2'b01: begin
                field <= ~field;
                phase <= 2'd0;
              end
              2'b10: begin
                phase <= phase_next;
                field <= phase_next[0];
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
